// File: rtl/branch_predictor_ctrl_if.sv
// Fetch-lookup and execute-resolution signals shared by the pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PCF;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  logic            BranchE;
  logic            JumpE;
  logic            JalrE;
  logic            TakenE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCTargetE;
  logic            PredTakenE;
  logic [XLEN-1:0] PredTargetE;
  logic            MispredictE;
  logic [XLEN-1:0] PCRedirectE;
  logic [31:0]     BranchCount;
  logic [31:0]     MispredCount;

  modport master (
    output PCF, BranchE, JumpE, JalrE, TakenE, PCE, PCTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, PCRedirectE, BranchCount, MispredCount
  );

  modport slave (
    input  PCF, BranchE, JumpE, JalrE, TakenE, PCE, PCTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, PCRedirectE, BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch prediction, E-stage
// mispredict/redirect, table update written at the end of the E cycle (read-before-write).
module branch_predictor_ctrl #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6
) (
  input logic                  clk,
  input logic                  reset,
  branch_predictor_ctrl_if.slave bp
);
  localparam int TAG_BITS = XLEN - INDEX_BITS - 2;
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [31:0]         branch_count_q;
  logic [31:0]         mispred_count_q;

  logic [INDEX_BITS-1:0] idx_f;
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0]   tag_f;
  logic [TAG_BITS-1:0]   tag_e;
  logic                  hit_f;
  logic                  tag_match_e;
  logic                  hit_e;
  logic                  pred_taken;
  logic                  is_ctrl;
  logic                  stray;
  logic                  actual;
  logic [XLEN-1:0]       next_pc;
  logic                  mispredict;

  assign idx_f = bp.PCF[INDEX_BITS+1:2];
  assign tag_f = bp.PCF[XLEN-1:INDEX_BITS+2];
  assign idx_e = bp.PCE[INDEX_BITS+1:2];
  assign tag_e = bp.PCE[XLEN-1:INDEX_BITS+2];

  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign tag_match_e = (tag_q[idx_e] == tag_e);
  assign hit_e       = valid_q[idx_e] && tag_match_e;

  assign pred_taken     = !reset && hit_f && ctr_q[idx_f][1];
  assign bp.PredTakenF  = pred_taken;
  assign bp.PredTargetF = pred_taken ? target_q[idx_f] : '0;

  assign is_ctrl = bp.BranchE || bp.JumpE;
  // A taken prediction on something that turned out not to be a control transfer.
  assign stray   = bp.PredTakenE && !is_ctrl && !bp.JalrE;
  assign actual  = bp.JumpE || (bp.BranchE && bp.TakenE);
  assign next_pc = actual ? bp.PCTargetE : (bp.PCE + PC_STEP);

  always_comb begin
    mispredict = 1'b0;
    if (!reset && !bp.JalrE) begin
      if (is_ctrl) begin
        mispredict = (bp.PredTakenE != actual) ||
                     (bp.PredTakenE && actual && (bp.PredTargetE != bp.PCTargetE));
      end else begin
        mispredict = bp.PredTakenE;
      end
    end
  end

  assign bp.MispredictE  = mispredict;
  assign bp.PCRedirectE  = mispredict ? next_pc : '0;
  assign bp.BranchCount  = branch_count_q;
  assign bp.MispredCount = mispred_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= '0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else begin
      if (is_ctrl)    branch_count_q  <= branch_count_q + 32'd1;
      if (mispredict) mispred_count_q <= mispred_count_q + 32'd1;

      // jalr targets are register-dependent, so a stale entry is dropped rather than trained.
      if (bp.JalrE || stray) begin
        if (tag_match_e) valid_q[idx_e] <= 1'b0;
      end else if (bp.JumpE) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= bp.PCTargetE;
        ctr_q[idx_e]    <= 2'b11;
      end else if (bp.BranchE) begin
        if (hit_e) begin
          if (bp.TakenE) begin
            if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
            target_q[idx_e] <= bp.PCTargetE;
          end else if (ctr_q[idx_e] != 2'b00) begin
            ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
          end
        end else if (bp.TakenE) begin
          valid_q[idx_e]  <= 1'b1;
          tag_q[idx_e]    <= tag_e;
          target_q[idx_e] <= bp.PCTargetE;
          ctr_q[idx_e]    <= 2'b10;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed scenarios plus randomized traffic checked against a table model of the predictor.
module tb_branch_predictor_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_ctrl_if #(.XLEN(32)) bp ();
  branch_predictor_ctrl dut (.clk(clk), .reset(reset), .bp(bp));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference table: one record per index, plain integers.
  bit          m_valid  [64];
  logic [31:0] m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  int unsigned m_bc, m_mc;

  // Current drive values and the model's verdict for this cycle.
  bit          d_rst, d_br, d_jmp, d_jalr, d_tkn, d_ptk;
  logic [31:0] d_pcf, d_pce, d_tgt, d_ptg;
  bit          e_mis;

  function automatic void m_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[(pc / 4) % 64] && (m_tag[(pc / 4) % 64] == pc / 256);
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[(pc / 4) % 64] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_target[(pc / 4) % 64] : 32'd0;
  endfunction

  task automatic apply(input bit rst, input logic [31:0] pcf, input bit br, input bit jmp,
                       input bit jalr, input bit tkn, input logic [31:0] pce,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptg);
    bit          act;
    logic [31:0] exp_redir;
    d_rst = rst; d_pcf = pcf; d_br = br; d_jmp = jmp; d_jalr = jalr; d_tkn = tkn;
    d_pce = pce; d_tgt = tgt; d_ptk = ptk; d_ptg = ptg;
    reset = rst; bp.PCF = pcf; bp.BranchE = br; bp.JumpE = jmp; bp.JalrE = jalr;
    bp.TakenE = tkn; bp.PCE = pce; bp.PCTargetE = tgt; bp.PredTakenE = ptk; bp.PredTargetE = ptg;
    @(negedge clk);
    act = jmp || (br && tkn);
    if (rst || jalr)   e_mis = 0;
    else if (br || jmp) e_mis = (ptk != act) || (ptk && act && ptg != tgt);
    else               e_mis = ptk;
    exp_redir = !e_mis ? 32'd0 : (act ? tgt : pce + 32'd4);
    check("pred_taken",  {31'd0, bp.PredTakenF}, rst ? 32'd0 : {31'd0, m_pred_taken(pcf)});
    check("pred_target", bp.PredTargetF, rst ? 32'd0 : m_pred_target(pcf));
    check("mispredict",  {31'd0, bp.MispredictE}, {31'd0, e_mis});
    check("redirect",    bp.PCRedirectE, exp_redir);
    check("branch_cnt",  bp.BranchCount, m_bc);
    check("mispred_cnt", bp.MispredCount, m_mc);
  endtask

  task automatic commit();
    int          idx;
    logic [31:0] tg;
    bit          hit;
    idx = (d_pce / 4) % 64;
    tg  = d_pce / 256;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (d_rst) begin
      m_clear();
    end else begin
      if (d_br || d_jmp) m_bc++;
      if (e_mis) m_mc++;
      if (d_jalr || (d_ptk && !d_br && !d_jmp)) begin
        if (m_tag[idx] == tg) m_valid[idx] = 0;
      end else if (d_jmp) begin
        m_valid[idx] = 1; m_tag[idx] = tg; m_target[idx] = d_tgt; m_ctr[idx] = 3;
      end else if (d_br) begin
        if (hit) begin
          if (d_tkn) begin
            m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
            m_target[idx] = d_tgt;
          end else begin
            m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
          end
        end else if (d_tkn) begin
          m_valid[idx] = 1; m_tag[idx] = tg; m_target[idx] = d_tgt; m_ctr[idx] = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pcf);
    apply(0, pcf, 0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic branch(input logic [31:0] pcf, input logic [31:0] pce, input bit tkn,
                        input logic [31:0] tgt);
    apply(0, pcf, 1, 0, 0, tkn, pce, tgt, m_pred_taken(pce), m_pred_target(pce));
  endtask

  logic [31:0] r_pce, r_pcf, r_tgt, r_ptg;
  bit          r_ptk;
  int          kind;

  initial begin
    m_clear();
    reset = 1'b1;
    bp.PCF = 0; bp.BranchE = 0; bp.JumpE = 0; bp.JalrE = 0; bp.TakenE = 0;
    bp.PCE = 0; bp.PCTargetE = 0; bp.PredTakenE = 0; bp.PredTargetE = 0;
    @(posedge clk); #1;
    apply(1, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    commit();

    // Cold start: miss, taken branch allocates, next lookup hits.
    apply(0, 32'h100, 1, 0, 0, 1, 32'h100, 32'h140, 0, 32'h0);
    check("t1_cold_pt", {31'd0, bp.PredTakenF}, 32'd0);
    check("t1_mis", {31'd0, bp.MispredictE}, 32'd1);
    check("t1_redir", bp.PCRedirectE, 32'h140);
    commit();
    idle(32'h100);
    check("t1_pt", {31'd0, bp.PredTakenF}, 32'd1);
    check("t1_ptg", bp.PredTargetF, 32'h140);
    commit();

    // Hysteresis.
    apply(0, 32'h100, 1, 0, 0, 0, 32'h100, 32'h140, 1, 32'h140);
    check("t2_mis", {31'd0, bp.MispredictE}, 32'd1);
    check("t2_redir", bp.PCRedirectE, 32'h104);
    commit();
    idle(32'h100);
    check("t2_pt01", {31'd0, bp.PredTakenF}, 32'd0);
    commit();
    repeat (3) begin
      branch(32'h0, 32'h100, 1, 32'h140);
      commit();
    end
    branch(32'h0, 32'h100, 0, 32'h140);
    check("t2_nt_mis", {31'd0, bp.MispredictE}, 32'd1);
    commit();
    idle(32'h100);
    check("t2_pt10", {31'd0, bp.PredTakenF}, 32'd1);
    commit();

    // Aliasing at index 0.
    idle(32'h200);
    check("t3_alias_miss", {31'd0, bp.PredTakenF}, 32'd0);
    commit();
    apply(0, 32'h0, 1, 0, 0, 1, 32'h200, 32'h240, 0, 32'h0);
    commit();
    idle(32'h100);
    check("t3_evicted", {31'd0, bp.PredTakenF}, 32'd0);
    commit();
    idle(32'h200);
    check("t3_new_ptg", bp.PredTargetF, 32'h240);
    commit();

    // jal target change.
    apply(0, 32'h0, 0, 1, 0, 0, 32'h300, 32'h340, 0, 32'h0);
    commit();
    apply(0, 32'h300, 0, 1, 0, 0, 32'h300, 32'h380, 1, 32'h340);
    check("t4_old_ptg", bp.PredTargetF, 32'h340);
    check("t4_mis", {31'd0, bp.MispredictE}, 32'd1);
    check("t4_redir", bp.PCRedirectE, 32'h380);
    commit();
    idle(32'h300);
    check("t4_new_ptg", bp.PredTargetF, 32'h380);
    commit();

    // Same-cycle lookup and update: ctr 01 -> 10.
    branch(32'h0, 32'h100, 1, 32'h140);
    commit();
    branch(32'h0, 32'h100, 0, 32'h140);
    commit();
    apply(0, 32'h100, 1, 0, 0, 1, 32'h100, 32'h140, 0, 32'h0);
    check("t5_same", {31'd0, bp.PredTakenF}, 32'd0);
    commit();
    idle(32'h100);
    check("t5_next", {31'd0, bp.PredTakenF}, 32'd1);
    commit();

    // Reset coinciding with a taken-branch update.
    apply(1, 32'h100, 1, 0, 0, 1, 32'h180, 32'h1c0, 1, 32'h0);
    check("t6_mis", {31'd0, bp.MispredictE}, 32'd0);
    check("t6_redir", bp.PCRedirectE, 32'd0);
    commit();
    idle(32'h180);
    check("t6_miss180", {31'd0, bp.PredTakenF}, 32'd0);
    check("t6_bc", bp.BranchCount, 32'd0);
    check("t6_mc", bp.MispredCount, 32'd0);
    commit();
    idle(32'h100);
    check("t6_miss100", {31'd0, bp.PredTakenF}, 32'd0);
    commit();

    // Randomized traffic over a small PC pool so hits, aliasing and same-cycle collisions recur.
    for (int n = 0; n < 3000; n++) begin
      r_pce = 32'h1000 + $urandom_range(0, 2) * 256 + $urandom_range(0, 7) * 4;
      r_pcf = ($urandom_range(0, 9) < 3) ? r_pce
            : 32'h1000 + $urandom_range(0, 2) * 256 + $urandom_range(0, 7) * 4;
      r_tgt = 32'h2000 + $urandom_range(0, 3) * 4;
      if ($urandom_range(0, 9) < 7) begin
        r_ptk = m_pred_taken(r_pce);
        r_ptg = m_pred_target(r_pce);
      end else begin
        r_ptk = 1'($urandom_range(0, 1));
        r_ptg = 32'h2000 + $urandom_range(0, 3) * 4;
      end
      kind = $urandom_range(0, 99);
      apply($urandom_range(0, 99) == 0, r_pcf, kind < 45, kind >= 45 && kind < 60,
            kind >= 60 && kind < 70, 1'($urandom_range(0, 1)), r_pce, r_tgt, r_ptk, r_ptg);
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
